// File: rtl/mdc_tcdm_periph_bridge.sv
// Flat-port bridge between an MDC HWPE core and the cluster TCDM/peripheral buses.
// Define MDC_BRIDGE_TCDM_SLICE_EN to insert the 2-entry TCDM request slice with OUTST credit limit.
module mdc_tcdm_periph_bridge #(
  parameter int N_CORES = 2,
  parameter int N_EVT   = 4,
  parameter int MP      = 4,
  parameter int ID      = 10,
  parameter int OUTST   = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_CORES-1:0][N_EVT-1:0]   acc_evt_i,
  output logic [N_CORES-1:0][N_EVT-1:0]   evt_o,
  input  logic [MP-1:0]                   acc_tcdm_req_i,
  input  logic [MP-1:0][31:0]             acc_tcdm_add_i,
  input  logic [MP-1:0]                   acc_tcdm_wen_i,
  input  logic [MP-1:0][3:0]              acc_tcdm_be_i,
  input  logic [MP-1:0][31:0]             acc_tcdm_data_i,
  output logic [MP-1:0]                   acc_tcdm_gnt_o,
  output logic [MP-1:0][31:0]             acc_tcdm_r_data_o,
  output logic [MP-1:0]                   acc_tcdm_r_valid_o,
  output logic [MP-1:0]                   tcdm_req,
  output logic [MP-1:0][31:0]             tcdm_add,
  output logic [MP-1:0]                   tcdm_wen,
  output logic [MP-1:0][3:0]              tcdm_be,
  output logic [MP-1:0][31:0]             tcdm_data,
  input  logic [MP-1:0]                   tcdm_gnt,
  input  logic [MP-1:0][31:0]             tcdm_r_data,
  input  logic [MP-1:0]                   tcdm_r_valid,
  input  logic                            periph_req,
  input  logic [31:0]                     periph_add,
  input  logic                            periph_wen,
  input  logic [3:0]                      periph_be,
  input  logic [31:0]                     periph_data,
  input  logic [ID-1:0]                   periph_id,
  output logic                            periph_gnt,
  output logic [31:0]                     periph_r_data,
  output logic                            periph_r_valid,
  output logic [ID-1:0]                   periph_r_id,
  output logic                            acc_periph_req_o,
  output logic [31:0]                     acc_periph_add_o,
  output logic                            acc_periph_wen_o,
  output logic [3:0]                      acc_periph_be_o,
  output logic [31:0]                     acc_periph_data_o,
  input  logic                            acc_periph_gnt_i,
  input  logic [31:0]                     acc_periph_r_data_i,
  input  logic                            acc_periph_r_valid_i,
  output logic [MP-1:0]                   tcdm_busy_o,
  output logic [MP-1:0]                   tcdm_err_o
);

  for (genvar c = 0; c < MP; c++) begin : g_ch
    logic [3:0] ocnt;
    logic       err;
    logic       issue;

`ifdef MDC_BRIDGE_TCDM_SLICE_EN
    logic [68:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  bcnt;
    logic        push;
    logic [4:0]  credits_used;

    // Buffered entries consume credits too, so the limit covers everything not yet answered.
    assign credits_used      = {3'b000, bcnt} + {1'b0, ocnt};
    assign acc_tcdm_gnt_o[c] = (bcnt < 2'd2) && (credits_used < 5'(OUTST));
    assign push              = acc_tcdm_req_i[c] && acc_tcdm_gnt_o[c];
    assign tcdm_req[c]       = (bcnt != 2'd0);
    assign issue             = tcdm_req[c] && tcdm_gnt[c];
    assign {tcdm_add[c], tcdm_wen[c], tcdm_be[c], tcdm_data[c]} = mem[rd_ptr];
    assign tcdm_busy_o[c]    = (bcnt != 2'd0) || (ocnt != 4'd0);

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr] <= {acc_tcdm_add_i[c], acc_tcdm_wen_i[c], acc_tcdm_be_i[c], acc_tcdm_data_i[c]};
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        bcnt   <= 2'd0;
      end else begin
        if (push)  wr_ptr <= ~wr_ptr;
        if (issue) rd_ptr <= ~rd_ptr;
        if (push && !issue)      bcnt <= bcnt + 2'd1;
        else if (!push && issue) bcnt <= bcnt - 2'd1;
      end
    end
`else
    assign tcdm_req[c]       = acc_tcdm_req_i[c];
    assign tcdm_add[c]       = acc_tcdm_add_i[c];
    assign tcdm_wen[c]       = acc_tcdm_wen_i[c];
    assign tcdm_be[c]        = acc_tcdm_be_i[c];
    assign tcdm_data[c]      = acc_tcdm_data_i[c];
    assign acc_tcdm_gnt_o[c] = tcdm_gnt[c];
    assign issue             = tcdm_req[c] && tcdm_gnt[c];
    assign tcdm_busy_o[c]    = (ocnt != 4'd0);
`endif

    // A response with nothing outstanding is flagged but never drives the count negative.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ocnt <= 4'd0;
        err  <= 1'b0;
      end else begin
        if (tcdm_r_valid[c] && (ocnt == 4'd0)) err <= 1'b1;
        if (issue && !tcdm_r_valid[c] && (ocnt != 4'hF))      ocnt <= ocnt + 4'd1;
        else if (!issue && tcdm_r_valid[c] && (ocnt != 4'd0)) ocnt <= ocnt - 4'd1;
      end
    end

    assign tcdm_err_o[c]         = err;
    assign acc_tcdm_r_valid_o[c] = tcdm_r_valid[c];
    assign acc_tcdm_r_data_o[c]  = tcdm_r_data[c];
  end

  logic          pend;
  logic [ID-1:0] id_q;

  assign periph_gnt        = acc_periph_gnt_i && !pend;
  assign acc_periph_req_o  = periph_req && !pend;
  assign acc_periph_add_o  = periph_add;
  assign acc_periph_wen_o  = periph_wen;
  assign acc_periph_be_o   = periph_be;
  assign acc_periph_data_o = periph_data;

  // pend drops on the registering edge so a new grant can overlap the returned response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend           <= 1'b0;
      id_q           <= '0;
      periph_r_valid <= 1'b0;
      periph_r_data  <= 32'd0;
      periph_r_id    <= '0;
    end else begin
      periph_r_valid <= acc_periph_r_valid_i;
      if (acc_periph_r_valid_i) begin
        periph_r_data <= acc_periph_r_data_i;
        periph_r_id   <= id_q;
      end
      if (acc_periph_req_o && acc_periph_gnt_i) begin
        pend <= 1'b1;
        id_q <= periph_id;
      end else if (acc_periph_r_valid_i) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) evt_o <= '0;
    else       evt_o <= acc_evt_i;
  end

endmodule

// File: tb/tb_mdc_tcdm_periph_bridge.sv
// Self-checking bench for mdc_tcdm_periph_bridge: directed phases plus randomized TCDM traffic
// checked against a queue-based reference; follows MDC_BRIDGE_TCDM_SLICE_EN like the design.
module tb_mdc_tcdm_periph_bridge;
  localparam int N_CORES = 2;
  localparam int N_EVT   = 4;
  localparam int MP      = 4;
  localparam int ID      = 10;
  localparam int OUTST   = 4;
`ifdef MDC_BRIDGE_TCDM_SLICE_EN
  localparam bit SLICE = 1'b1;
`else
  localparam bit SLICE = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } req_t;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic [N_CORES-1:0][N_EVT-1:0] acc_evt_i, evt_o;
  logic [MP-1:0]                 acc_tcdm_req_i, acc_tcdm_wen_i, acc_tcdm_gnt_o, acc_tcdm_r_valid_o;
  logic [MP-1:0][31:0]           acc_tcdm_add_i, acc_tcdm_data_i, acc_tcdm_r_data_o;
  logic [MP-1:0][3:0]            acc_tcdm_be_i, tcdm_be;
  logic [MP-1:0]                 tcdm_req, tcdm_wen, tcdm_gnt, tcdm_r_valid, tcdm_busy_o, tcdm_err_o;
  logic [MP-1:0][31:0]           tcdm_add, tcdm_data, tcdm_r_data;
  logic                          periph_req, periph_wen, periph_gnt, periph_r_valid;
  logic [31:0]                   periph_add, periph_data, periph_r_data;
  logic [3:0]                    periph_be, acc_periph_be_o;
  logic [ID-1:0]                 periph_id, periph_r_id;
  logic                          acc_periph_req_o, acc_periph_wen_o, acc_periph_gnt_i, acc_periph_r_valid_i;
  logic [31:0]                   acc_periph_add_o, acc_periph_data_o, acc_periph_r_data_i;

  mdc_tcdm_periph_bridge #(
    .N_CORES(N_CORES), .N_EVT(N_EVT), .MP(MP), .ID(ID), .OUTST(OUTST)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .acc_evt_i(acc_evt_i), .evt_o(evt_o),
    .acc_tcdm_req_i(acc_tcdm_req_i), .acc_tcdm_add_i(acc_tcdm_add_i), .acc_tcdm_wen_i(acc_tcdm_wen_i),
    .acc_tcdm_be_i(acc_tcdm_be_i), .acc_tcdm_data_i(acc_tcdm_data_i), .acc_tcdm_gnt_o(acc_tcdm_gnt_o),
    .acc_tcdm_r_data_o(acc_tcdm_r_data_o), .acc_tcdm_r_valid_o(acc_tcdm_r_valid_o),
    .tcdm_req(tcdm_req), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be),
    .tcdm_data(tcdm_data), .tcdm_gnt(tcdm_gnt), .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid),
    .periph_req(periph_req), .periph_add(periph_add), .periph_wen(periph_wen), .periph_be(periph_be),
    .periph_data(periph_data), .periph_id(periph_id), .periph_gnt(periph_gnt),
    .periph_r_data(periph_r_data), .periph_r_valid(periph_r_valid), .periph_r_id(periph_r_id),
    .acc_periph_req_o(acc_periph_req_o), .acc_periph_add_o(acc_periph_add_o),
    .acc_periph_wen_o(acc_periph_wen_o), .acc_periph_be_o(acc_periph_be_o),
    .acc_periph_data_o(acc_periph_data_o), .acc_periph_gnt_i(acc_periph_gnt_i),
    .acc_periph_r_data_i(acc_periph_r_data_i), .acc_periph_r_valid_i(acc_periph_r_valid_i),
    .tcdm_busy_o(tcdm_busy_o), .tcdm_err_o(tcdm_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference state: per-channel buffered requests, outstanding count and sticky error.
`ifdef MDC_BRIDGE_TCDM_SLICE_EN
  req_t bufq [MP][$];
`endif
  int                            ocnt_m [MP];
  bit                            err_m  [MP];
  logic [MP-1:0]                 due;
  logic [N_CORES-1:0][N_EVT-1:0] evt_prev;
  int                            obs_acc [MP];
  int                            obs_rsp [MP];
  logic [MP-1:0]                 obs_busy;
  int                            n_assert;
  int                            n_fail;

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [MP-1:0] outst_mask();
    logic [MP-1:0] m;
    for (int c = 0; c < MP; c++) m[c] = (ocnt_m[c] != 0);
    return m;
  endfunction

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // One TCDM cycle: drive at posedge+1, check at the falling edge, then advance the reference.
  task automatic applyStimulus(input logic rst, input logic [MP-1:0] req,
                               input logic [MP-1:0] gnt, input logic [MP-1:0] rv);
    req_t          cur [MP];
    logic [31:0]   rdata [MP];
    logic [MP-1:0] exp_gnt, exp_req;
    rst_i          = rst;
    acc_evt_i      = (N_CORES*N_EVT)'($urandom);
    acc_tcdm_req_i = req;
    tcdm_gnt       = gnt;
    tcdm_r_valid   = rv;
    for (int c = 0; c < MP; c++) begin
      cur[c]             = {$urandom, 1'($urandom), 4'($urandom), $urandom};
      acc_tcdm_add_i[c]  = cur[c].add;
      acc_tcdm_wen_i[c]  = cur[c].wen;
      acc_tcdm_be_i[c]   = cur[c].be;
      acc_tcdm_data_i[c] = cur[c].data;
      rdata[c]           = $urandom;
      tcdm_r_data[c]     = rdata[c];
    end
    #4;
    checkOutput("evt", evt_o, evt_prev);
    for (int c = 0; c < MP; c++) begin
      req_t hd;
      logic ebusy;
      hd = '0;
`ifdef MDC_BRIDGE_TCDM_SLICE_EN
      exp_gnt[c] = (bufq[c].size() < 2) && ((bufq[c].size() + ocnt_m[c]) < OUTST);
      exp_req[c] = (bufq[c].size() != 0);
      if (exp_req[c]) hd = bufq[c][0];
      ebusy = exp_req[c] || (ocnt_m[c] != 0);
`else
      exp_gnt[c] = gnt[c];
      exp_req[c] = req[c];
      hd         = cur[c];
      ebusy      = (ocnt_m[c] != 0);
`endif
      checkOutput($sformatf("acc_gnt[%0d]", c), acc_tcdm_gnt_o[c], exp_gnt[c]);
      checkOutput($sformatf("tcdm_req[%0d]", c), tcdm_req[c], exp_req[c]);
      if (exp_req[c])
        checkOutput($sformatf("tcdm_head[%0d]", c), {tcdm_add[c], tcdm_wen[c], tcdm_be[c], tcdm_data[c]}, hd);
      checkOutput($sformatf("busy[%0d]", c), tcdm_busy_o[c], ebusy);
      checkOutput($sformatf("err[%0d]", c), tcdm_err_o[c], err_m[c]);
      checkOutput($sformatf("r_valid[%0d]", c), acc_tcdm_r_valid_o[c], rv[c]);
      if (rv[c]) checkOutput($sformatf("r_data[%0d]", c), acc_tcdm_r_data_o[c], rdata[c]);
      if (req[c] && acc_tcdm_gnt_o[c] === 1'b1) obs_acc[c]++;
      if (acc_tcdm_r_valid_o[c] === 1'b1) obs_rsp[c]++;
    end
    obs_busy = tcdm_busy_o;
    if (rst) begin
      for (int c = 0; c < MP; c++) begin
`ifdef MDC_BRIDGE_TCDM_SLICE_EN
        bufq[c].delete();
`endif
        ocnt_m[c] = 0;
        err_m[c]  = 1'b0;
      end
      due      = '0;
      evt_prev = '0;
    end else begin
      for (int c = 0; c < MP; c++) begin
        logic pop;
        pop = exp_req[c] && gnt[c];
        if (rv[c] && ocnt_m[c] == 0) err_m[c] = 1'b1;
        if (pop && !rv[c]) begin
          if (ocnt_m[c] < 15) ocnt_m[c]++;
        end else if (rv[c] && !pop && ocnt_m[c] > 0) begin
          ocnt_m[c]--;
        end
`ifdef MDC_BRIDGE_TCDM_SLICE_EN
        if (pop) void'(bufq[c].pop_front());
        if (req[c] && exp_gnt[c]) bufq[c].push_back(cur[c]);
`endif
        due[c] = pop;
      end
      evt_prev = acc_evt_i;
    end
    nextCycle();
  endtask

  initial begin
    int cycles;
    int tail;
    n_assert = 0;
    n_fail   = 0;
    due      = '0;
    evt_prev = '0;
    for (int c = 0; c < MP; c++) begin
      ocnt_m[c]  = 0;
      err_m[c]   = 1'b0;
      obs_acc[c] = 0;
      obs_rsp[c] = 0;
    end
    rst_i = 1'b1;
    acc_evt_i = '0;
    acc_tcdm_req_i = '0; acc_tcdm_add_i = '0; acc_tcdm_wen_i = '0; acc_tcdm_be_i = '0; acc_tcdm_data_i = '0;
    tcdm_gnt = '0; tcdm_r_data = '0; tcdm_r_valid = '0;
    periph_req = 1'b0; periph_add = '0; periph_wen = 1'b0; periph_be = '0; periph_data = '0; periph_id = '0;
    acc_periph_gnt_i = 1'b0; acc_periph_r_data_i = '0; acc_periph_r_valid_i = 1'b0;
    nextCycle();

    $display("[TB] reset");
    applyStimulus(1'b1, '0, '1, '0);
    applyStimulus(1'b1, '0, '1, '0);
    rst_i = 1'b0;
    #1;
    checkOutput("rst_evt", evt_o, 0);
    checkOutput("rst_tcdm_req", tcdm_req, 0);
    checkOutput("rst_gnt", acc_tcdm_gnt_o, {MP{1'b1}});
    checkOutput("rst_busy", tcdm_busy_o, 0);
    checkOutput("rst_err", tcdm_err_o, 0);
    checkOutput("rst_p_r_valid", periph_r_valid, 0);
    checkOutput("rst_p_r_id", periph_r_id, 0);
    checkOutput("rst_p_r_data", periph_r_data, 0);

    $display("[TB] credit limit with cluster grant held low");
    obs_acc[0] = 0;
    repeat (5) applyStimulus(1'b0, 4'b0001, '0, '0);
    checkOutput("credit_accepts", obs_acc[0], SLICE ? 2 : 0);
    checkOutput("credit_gnt_low", acc_tcdm_gnt_o[0], 0);
    checkOutput("credit_busy", tcdm_busy_o[0], SLICE ? 1 : 0);
    repeat (8) applyStimulus(1'b0, '0, '1, outst_mask());

    $display("[TB] 100-request stream");
    obs_acc[0] = 0;
    obs_rsp[0] = 0;
    cycles = 0;
    while (obs_acc[0] < 100 && cycles < 300) begin
      applyStimulus(1'b0, '1, '1, due);
      cycles++;
    end
    checkOutput("stream_accepts", obs_acc[0], 100);
    checkOutput("stream_cycles", cycles, 100);
    tail = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, '1, due);
      if (obs_busy[0] === 1'b1) tail++;
    end
    checkOutput("busy_tail", tail, SLICE ? 2 : 1);
    checkOutput("stream_responses", obs_rsp[0], 100);

    $display("[TB] credit exhaustion and return");
    repeat (6) applyStimulus(1'b0, 4'b0001, 4'b0001, '0);
    checkOutput("exhaust_gnt", acc_tcdm_gnt_o[0], SLICE ? 0 : 1);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001);
    checkOutput("credit_return_gnt", acc_tcdm_gnt_o[0], 1);
    repeat (12) applyStimulus(1'b0, '0, '1, outst_mask());

    $display("[TB] response on idle channel");
    applyStimulus(1'b0, '0, '1, 4'b0100);
    repeat (3) applyStimulus(1'b0, '0, '1, '0);
    checkOutput("err_sticky", tcdm_err_o[2], 1);

    $display("[TB] reset mid-transaction");
    repeat (3) applyStimulus(1'b0, 4'b0001, 4'b0001, '0);
    applyStimulus(1'b0, 4'b0001, '0, '0);
    applyStimulus(1'b1, '0, '1, '0);
    checkOutput("midrst_tcdm_req", tcdm_req[0], 0);
    checkOutput("midrst_gnt", acc_tcdm_gnt_o[0], 1);
    checkOutput("midrst_busy", tcdm_busy_o[0], 0);
    checkOutput("midrst_err_clear", tcdm_err_o[2], 0);
    applyStimulus(1'b0, '0, '1, 4'b0001);
    checkOutput("late_rsp_err", tcdm_err_o[0], 1);

    $display("[TB] randomized TCDM traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, MP'($urandom), MP'($urandom), outst_mask() & MP'($urandom));
    repeat (20) applyStimulus(1'b0, '0, '1, outst_mask());

    $display("[TB] peripheral path");
    periph_req = 1'b1; periph_add = $urandom; periph_id = 10'h155; acc_periph_gnt_i = 1'b0;
    #4;
    checkOutput("p_gnt_blocked", periph_gnt, 0);
    checkOutput("p_req_fwd", acc_periph_req_o, 1);
    nextCycle();
    for (int t = 0; t < 8; t++) begin
      logic [ID-1:0] pid;
      logic [31:0]   pdata, padd, pwdata;
      logic [3:0]    pbe;
      int            lat;
      pid    = (t == 0) ? 10'h2A5 : ID'($urandom);
      pdata  = (t == 0) ? 32'hDEADBEEF : $urandom;
      lat    = (t == 0) ? 2 : $urandom_range(1, 3);
      padd   = $urandom;
      pwdata = $urandom;
      pbe    = 4'($urandom);
      periph_req = 1'b1; periph_add = padd; periph_wen = t[0]; periph_be = pbe;
      periph_data = pwdata; periph_id = pid;
      acc_periph_gnt_i = 1'b1; acc_periph_r_valid_i = 1'b0;
      #4;
      checkOutput("p_gnt", periph_gnt, 1);
      checkOutput("p_req_o", acc_periph_req_o, 1);
      checkOutput("p_fields_o", {acc_periph_add_o, acc_periph_wen_o, acc_periph_be_o, acc_periph_data_o},
                  {padd, t[0], pbe, pwdata});
      checkOutput("p_r_valid_idle", periph_r_valid, 0);
      nextCycle();
      for (int k = 1; k < lat; k++) begin
        periph_id = ~pid;
        #4;
        checkOutput("p_gnt_pend", periph_gnt, 0);
        checkOutput("p_req_pend", acc_periph_req_o, 0);
        nextCycle();
      end
      periph_req = 1'b0;
      acc_periph_r_valid_i = 1'b1; acc_periph_r_data_i = pdata;
      #4;
      checkOutput("p_r_valid_early", periph_r_valid, 0);
      nextCycle();
      acc_periph_r_valid_i = 1'b0; acc_periph_r_data_i = $urandom;
      #4;
      checkOutput("p_r_valid", periph_r_valid, 1);
      checkOutput("p_r_data", periph_r_data, pdata);
      checkOutput("p_r_id", periph_r_id, pid);
      checkOutput("p_gnt_reopen", periph_gnt, 1);
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
